mdu: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage of the five-stage MIPS pipeline, alongside the ALU and fed by the same forwarded operand pair. It executes MULT/MULTU/DIV/DIVU over a fixed cycle count, owns the HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO. The hazard unit stalls any MDU instruction in D while `busy` or `start` is high.

---
 rtl/mdu.sv | 160 ++++++++++++++++
 tb/tb_mdu.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit for the EX stage: owns HI/LO, runs MULT/DIV
// over a fixed cycle count and serves MFHI/MFLO/MTHI/MTLO.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] I1,
    input  logic [31:0] I2,
    input  logic [3:0]  MDUop,
    input  logic        start,
    output logic        busy,
    output logic [31:0] OUT,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] res_hi_q;
    logic [31:0] res_lo_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;

    logic        accept_s;
    logic        is_mult_s;
    logic [63:0] prod_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [31:0] den_s;
    logic [31:0] quo_mag_s;
    logic [31:0] rem_mag_s;
    logic [31:0] res_hi_d;
    logic [31:0] res_lo_d;

    // Operation decode and one-shot result computation for the accepting edge.
    always_comb begin
        accept_s  = 1'b0;
        is_mult_s = 1'b0;
        if (state_q == IDLE && start && MDUop >= 4'd1 && MDUop <= 4'd4) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (MDUop == 4'd1 || MDUop == 4'd2) begin
            is_mult_s = 1'b1;
        end else begin
            is_mult_s = 1'b0;
        end

        // Sign-extending before an unsigned 64-bit multiply yields the signed product mod 2^64.
        if (MDUop == 4'd1) begin
            prod_s = {{32{I1[31]}}, I1} * {{32{I2[31]}}, I2};
        end else begin
            prod_s = {32'd0, I1} * {32'd0, I2};
        end

        a_neg_s   = (MDUop == 4'd3) & I1[31];
        b_neg_s   = (MDUop == 4'd3) & I2[31];
        abs_a_s   = a_neg_s ? (32'd0 - I1) : I1;
        abs_b_s   = b_neg_s ? (32'd0 - I2) : I2;
        den_s     = (I2 == 32'd0) ? 32'd1 : abs_b_s;
        quo_mag_s = abs_a_s / den_s;
        rem_mag_s = abs_a_s % den_s;

        res_hi_d = hi_q;
        res_lo_d = lo_q;
        case (MDUop)
            4'd1, 4'd2: begin
                res_hi_d = prod_s[63:32];
                res_lo_d = prod_s[31:0];
            end
            4'd3, 4'd4: begin
                if (I2 == 32'd0) begin
                    res_hi_d = hi_q;
                    res_lo_d = lo_q;
                end else begin
                    res_lo_d = (a_neg_s ^ b_neg_s) ? (32'd0 - quo_mag_s) : quo_mag_s;
                    res_hi_d = a_neg_s ? (32'd0 - rem_mag_s) : rem_mag_s;
                end
            end
            default: begin
                res_hi_d = hi_q;
                res_lo_d = lo_q;
            end
        endcase
    end

    // FSM, countdown, result staging and HI/LO commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        res_hi_q <= res_hi_d;
                        res_lo_q <= res_lo_d;
                        cnt_q    <= is_mult_s ? MULT_N : DIV_N;
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                    end else if (MDUop == 4'd7) begin
                        hi_q <= I1;
                    end else if (MDUop == 4'd8) begin
                        lo_q <= I1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        hi_q    <= res_hi_q;
                        lo_q    <= res_lo_q;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // MFHI/MFLO read port always shows committed HI/LO.
    always_comb begin
        case (MDUop)
            4'd5:    OUT = hi_q;
            4'd6:    OUT = lo_q;
            default: OUT = 32'd0;
        endcase
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected commits, a monitor checks
// them when busy falls, against an arithmetic reference model.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] I1 = 32'd0;
    logic [31:0] I2 = 32'd0;
    logic [3:0]  MDUop = 4'd0;
    logic        start = 1'b0;
    logic        busy;
    logic [31:0] OUT;
    logic [31:0] HI;
    logic [31:0] LO;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .I1(I1), .I2(I2), .MDUop(MDUop),
        .start(start), .busy(busy), .OUT(OUT), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain 64-bit arithmetic, SV integer division truncates toward zero.
    task automatic ref_op(input int op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l);
        longint      sa, sbv, q, r;
        logic [63:0] p, ua, ub;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        h   = model_hi;
        l   = model_lo;
        if (op == 1) begin
            p = 64'(sa * sbv);
            h = p[63:32];
            l = p[31:0];
        end else if (op == 2) begin
            p = ua * ub;
            h = p[63:32];
            l = p[31:0];
        end else if (b != 32'd0) begin
            if (op == 3) begin
                q = sa / sbv;
                r = sa % sbv;
                l = q[31:0];
                h = r[31:0];
            end else begin
                p = ua / ub;
                l = p[31:0];
                p = ua % ub;
                h = p[31:0];
            end
        end
    endtask

    task automatic check_out();
        MDUop = 4'd5;
        #1;
        chk("mfhi", OUT, model_hi);
        MDUop = 4'd6;
        #1;
        chk("mflo", OUT, model_lo);
        MDUop = 4'd0;
    endtask

    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        ref_op(op, a, b, e.hi, e.lo);
        e.cyc   = (op <= 2) ? 5 : 10;
        pend_hi = e.hi;
        pend_lo = e.lo;
        sb.push_back(e);
        I1 = a;
        I2 = b;
        MDUop = 4'(op);
        start = 1'b1;
        step();
        start = 1'b0;
        MDUop = 4'd6;
        #1;
        chk("mflo_old_during_busy", OUT, model_lo);
        MDUop = 4'd0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL busy_timeout actual=1 required=0");
        end
        model_hi = pend_hi;
        model_lo = pend_lo;
    endtask

    task automatic mt(input bit hi_sel, input logic [31:0] v);
        I1 = v;
        MDUop = hi_sel ? 4'd7 : 4'd8;
        step();
        MDUop = 4'd0;
        if (hi_sel) model_hi = v;
        else model_lo = v;
        chk(hi_sel ? "mthi_hi" : "mtlo_lo", hi_sel ? HI : LO, v);
    endtask

    // Monitor: on each busy fall, pop the expected commit and check HI/LO and busy length.
    initial begin
        bit prev = 1'b0;
        int bcnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev = 1'b0;
                bcnt = 0;
            end else begin
                if (busy) bcnt++;
                if (prev && !busy) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_commit actual=%0d required=0", 1);
                    end else begin
                        e = sb.pop_front();
                        chk("commit_hi", HI, e.hi);
                        chk("commit_lo", LO, e.lo);
                        chk("busy_cycles", 32'(bcnt), 32'(e.cyc));
                    end
                    bcnt = 0;
                end
                prev = busy;
            end
        end
    end

    initial begin
        int          r, op;
        logic [31:0] a, b;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_out", OUT, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();

        issue(1, 32'hFFFFFFFE, 32'd3);
        wait_done();
        check_out();
        issue(2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done();
        check_out();
        issue(3, 32'hFFFFFFF9, 32'd2);
        wait_done();
        check_out();
        mt(1'b1, 32'h1234);
        mt(1'b0, 32'h5678);
        issue(4, 32'd99, 32'd0);
        wait_done();
        check_out();
        issue(3, 32'h80000000, 32'hFFFFFFFF);
        wait_done();
        check_out();

        // MTLO at cycle 2 and a fresh start at cycle 3 of a MULT must both be ignored.
        issue(1, 32'd1000, 32'hFFFFFFF0);
        MDUop = 4'd8;
        I1 = 32'hDEADBEEF;
        step();
        MDUop = 4'd1;
        start = 1'b1;
        I1 = 32'd9;
        I2 = 32'd9;
        step();
        start = 1'b0;
        MDUop = 4'd0;
        wait_done();
        check_out();

        // Reset mid-DIV: abort without commit.
        issue(3, 32'd1000, 32'd7);
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", HI, 32'd0);
        chk("rst_mid_lo", LO, 32'd0);
        sb.delete();
        model_hi = 32'd0;
        model_lo = 32'd0;
        step();
        reset_n = 1'b1;
        step();
        issue(1, 32'd6, 32'd7);
        wait_done();
        check_out();

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                op = $urandom_range(1, 4);
                a = $urandom;
                case ($urandom_range(0, 3))
                    0: b = 32'd0;
                    1: b = 32'($urandom_range(1, 9));
                    2: b = 32'hFFFFFFFF;
                    default: b = $urandom;
                endcase
                issue(op, a, b);
                wait_done();
            end else if (r <= 7) begin
                mt(r == 6, $urandom);
            end else begin
                check_out();
            end
        end

        step();
        step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
